// File: rtl/reg_status_file.sv
// ---------------------------------------------------------------------------
// reg_status_file
//
// Architectural register file with a rename label per register, as used by a
// Tomasulo-style issue stage. Each register holds a value and a label. Label
// zero means the value in the file is current. A nonzero label names the
// reservation-station/FU entry that will produce the next value.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   readAddr1/readAddr2      issue-stage source registers (rs, rt)
//   labelOut1/labelOut2      pending label per source, 0 when value is ready
//   dataOut1/dataOut2        register value per source (valid when label==0)
//   issueEn/issueAddr/
//   issueLabel               destination allocation for the issuing instr.
//   cdbValid/cdbLabel/
//   cdbData                  common data bus result broadcast
//   flush                    drop every pending label (recovery)
//   pendingCnt               registered count of registers still pending
// ---------------------------------------------------------------------------
module reg_status_file #(
  parameter int NREG = 32,
  parameter int DW   = 32,
  parameter int LW   = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    readAddr1,
  input  logic [4:0]    readAddr2,
  output logic [LW-1:0] labelOut1,
  output logic [LW-1:0] labelOut2,
  output logic [DW-1:0] dataOut1,
  output logic [DW-1:0] dataOut2,
  input  logic          issueEn,
  input  logic [4:0]    issueAddr,
  input  logic [LW-1:0] issueLabel,
  input  logic          cdbValid,
  input  logic [LW-1:0] cdbLabel,
  input  logic [DW-1:0] cdbData,
  input  logic          flush,
  output logic [5:0]    pendingCnt
);

  logic [DW-1:0] dataMem   [NREG];
  logic [LW-1:0] labelMem  [NREG];
  logic [DW-1:0] nextData  [NREG];
  logic [LW-1:0] nextLabel [NREG];
  logic [5:0]    nextCnt;

  // A CDB broadcast only means something when it carries a real label; label
  // zero would otherwise match every ready register and corrupt the file.
  logic cdbLive;
  assign cdbLive = cdbValid && (cdbLabel != '0);

  // Source port A. Register 0 is hardwired to zero. If the register is still
  // waiting on the producer that is broadcasting right now, forward the CDB
  // value so the issuing instruction does not have to wait one more cycle.
  // A same-cycle issue is deliberately invisible here so that an instruction
  // with rs==rd still reads its old producer.
  always_comb begin
    labelOut1 = labelMem[readAddr1];
    dataOut1  = dataMem[readAddr1];
    if (readAddr1 == '0) begin
      labelOut1 = '0;
      dataOut1  = '0;
    end else if (cdbLive && (labelMem[readAddr1] == cdbLabel)) begin
      labelOut1 = '0;
      dataOut1  = cdbData;
    end
  end

  // Source port B, identical in behaviour to port A.
  always_comb begin
    labelOut2 = labelMem[readAddr2];
    dataOut2  = dataMem[readAddr2];
    if (readAddr2 == '0) begin
      labelOut2 = '0;
      dataOut2  = '0;
    end else if (cdbLive && (labelMem[readAddr2] == cdbLabel)) begin
      labelOut2 = '0;
      dataOut2  = cdbData;
    end
  end

  // Next-state for every register. The CDB value is captured whenever the
  // stored label matches, even during a flush, so committed results are never
  // lost. For the label, flush beats everything, then a new issue beats the
  // CDB retire (the newer producer owns the register), then the retire.
  // The pending count is taken from the final labels, so it can never drift
  // from the table contents.
  always_comb begin
    nextData[0]  = '0;
    nextLabel[0] = '0;
    nextCnt      = '0;
    for (int i = 1; i < NREG; i++) begin
      logic hit;
      hit          = cdbLive && (labelMem[i] == cdbLabel);
      nextData[i]  = hit ? cdbData : dataMem[i];
      nextLabel[i] = labelMem[i];
      if (flush) begin
        nextLabel[i] = '0;
      end else if (issueEn && (issueAddr == 5'(i)) && (issueLabel != '0)) begin
        nextLabel[i] = issueLabel;
      end else if (hit) begin
        nextLabel[i] = '0;
      end
      nextCnt = nextCnt + {5'b0, (nextLabel[i] != '0)};
    end
  end

  // State update. Reset clears the whole table and the count and overrides
  // any issue, CDB or flush activity in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        dataMem[i]  <= '0;
        labelMem[i] <= '0;
      end
      pendingCnt <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        dataMem[i]  <= nextData[i];
        labelMem[i] <= nextLabel[i];
      end
      pendingCnt <= nextCnt;
    end
  end

endmodule
